// File: rtl/blip_burst_gen_pkg.sv
// Shared definitions for the blip burst generator: FSM state encodings and default clear length.
// The crosstalk counter bench imports the same package.
package blip_burst_gen_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int CLR_CYCLES_DEF = 4;

endpackage

// File: rtl/blip_burst_gen_phase_timer.sv
// Loadable down-counter timing one FSM phase; expire is high on the last cycle of the phase.
// A phase of P cycles is timed by loading P-1 on the edge that enters it.
module blip_burst_gen_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/blip_burst_gen.sv
// Blip burst generator: emits N clean pulses on blip_o, optionally pulsing counter_reset_o first.
// Outputs are flops loaded from the next-state decode, so each output lines up with its state.
module blip_burst_gen
  import blip_burst_gen_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int PER_W      = 8,
  parameter int CLR_CYCLES = CLR_CYCLES_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             active,
  input  logic             start,
  input  logic             clr_first,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [PER_W-1:0] high_cycles,
  input  logic [PER_W-1:0] low_cycles,
  input  logic             abort,
  output logic             blip_o,
  output logic             counter_reset_o,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] sent_count,
  output logic [2:0]       dbg_state
);

  localparam logic [PER_W-1:0] CLR_LOAD = PER_W'(CLR_CYCLES - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_len;
  logic [PER_W-1:0] r_high;
  logic [PER_W-1:0] r_low;

  logic [2:0]       w_next;
  logic             w_accept;
  logic             w_stop;
  logic             w_in_burst;
  logic             w_expire;
  logic             w_load;
  logic [PER_W-1:0] w_high_len;
  logic [PER_W-1:0] w_low_len;
  logic [PER_W-1:0] w_load_val;

  assign w_accept   = (r_state == ST_IDLE) && start && active;
  assign w_stop     = abort || !active;
  assign w_in_burst = (r_state == ST_CLEAR) || (r_state == ST_HIGH) || (r_state == ST_LOW);

  // In IDLE the config is being latched on this same edge, so time from the live inputs.
  assign w_high_len = (r_state == ST_IDLE) ? high_cycles : r_high;
  assign w_low_len  = (r_state == ST_IDLE) ? low_cycles  : r_low;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (burst_len == '0)  w_next = ST_DONE;
          else if (clr_first)   w_next = ST_CLEAR;
          else                  w_next = ST_HIGH;
        end
      end
      ST_CLEAR: begin
        if (w_stop)        w_next = ST_DONE;
        else if (w_expire) w_next = ST_HIGH;
      end
      ST_HIGH: begin
        if (w_stop)        w_next = ST_DONE;
        else if (w_expire) w_next = ST_LOW;
      end
      ST_LOW: begin
        if (w_stop)        w_next = ST_DONE;
        else if (w_expire) w_next = (sent_count < r_len) ? ST_HIGH : ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Zero-length phases are stretched to one cycle by saturating the load value at 0.
  always_comb begin
    w_load_val = '0;
    case (w_next)
      ST_CLEAR: w_load_val = CLR_LOAD;
      ST_HIGH:  w_load_val = (w_high_len == '0) ? '0 : w_high_len - PER_W'(1);
      ST_LOW:   w_load_val = (w_low_len == '0) ? '0 : w_low_len - PER_W'(1);
      default:  w_load_val = '0;
    endcase
  end

  assign w_load = (w_next != r_state) &&
                  ((w_next == ST_CLEAR) || (w_next == ST_HIGH) || (w_next == ST_LOW));

  blip_burst_gen_phase_timer #(.W(PER_W)) u_timer (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .expire   (w_expire)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state         <= ST_IDLE;
      r_len           <= '0;
      r_high          <= '0;
      r_low           <= '0;
      blip_o          <= 1'b0;
      counter_reset_o <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      aborted         <= 1'b0;
      sent_count      <= '0;
    end else begin
      r_state         <= w_next;
      blip_o          <= (w_next == ST_HIGH);
      counter_reset_o <= (w_next == ST_CLEAR);
      busy            <= (w_next != ST_IDLE);
      done            <= (w_next == ST_DONE);
      if (w_accept) begin
        r_len      <= burst_len;
        r_high     <= high_cycles;
        r_low      <= low_cycles;
        aborted    <= 1'b0;
        sent_count <= (w_next == ST_HIGH) ? CNT_W'(1) : '0;
      end else begin
        if (w_in_burst && w_stop) aborted <= 1'b1;
        // Counting on HIGH entry means an aborted partial pulse is still counted.
        if ((w_next == ST_HIGH) && (r_state != ST_HIGH)) sent_count <= sent_count + CNT_W'(1);
      end
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_blip_burst_gen.sv
// Directed bench for blip_burst_gen: per-cycle output patterns from hand-written strings.
module tb_blip_burst_gen;

  logic       clk;
  logic       rst_n;
  logic       active;
  logic       start;
  logic       clr_first;
  logic [7:0] burst_len;
  logic [7:0] high_cycles;
  logic [7:0] low_cycles;
  logic       abort;
  logic       blip_o;
  logic       counter_reset_o;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] sent_count;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q[$];

  blip_burst_gen dut (
    .wb_clk_i        (clk),
    .wb_rst_n        (rst_n),
    .active          (active),
    .start           (start),
    .clr_first       (clr_first),
    .burst_len       (burst_len),
    .high_cycles     (high_cycles),
    .low_cycles      (low_cycles),
    .abort           (abort),
    .blip_o          (blip_o),
    .counter_reset_o (counter_reset_o),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .sent_count      (sent_count),
    .dbg_state       (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // Per-cycle code: {blip_o, counter_reset_o, busy, done, done&aborted}
  function automatic logic [4:0] code(input byte c);
    case (c)
      "H":     return 5'b10100;
      "L":     return 5'b00100;
      "C":     return 5'b01100;
      "D":     return 5'b00110;
      "X":     return 5'b00111;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] obs_vec();
    return {blip_o, counter_reset_o, busy, done, done & aborted};
  endfunction

  // Checks one pattern char per cycle; start held high for the first hold_start steps,
  // abort high for the step after index abort_at.
  task automatic expect_seq(input string tag, input string pat, input int hold_start,
                            input int abort_at);
    for (int i = 0; i < pat.len(); i++) exp_q.push_back(code(pat[i]));
    for (int i = 0; i < pat.len(); i++) begin
      chk($sformatf("%s[%0d]", tag, i), 32'(obs_vec()), 32'(exp_q.pop_front()));
      start = (i < hold_start);
      abort = (i == abort_at);
      step();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic launch(input logic [7:0] n, input logic [7:0] h, input logic [7:0] l,
                        input logic clr, input logic with_abort);
    burst_len   = n;
    high_cycles = h;
    low_cycles  = l;
    clr_first   = clr;
    start       = 1'b1;
    abort       = with_abort;
    step();
    start       = 1'b0;
    abort       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; active = 1'b1; start = 1'b0; clr_first = 1'b0;
    burst_len = '0; high_cycles = '0; low_cycles = '0; abort = 1'b0;
    #3;
    chk("reset_outs", 32'(obs_vec()), 32'd0);
    chk("reset_sent", 32'(sent_count), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", 32'(obs_vec()), 32'd0);

    // N=3 H=2 L=1, no clear
    launch(8'd3, 8'd2, 8'd1, 1'b0, 1'b0);
    expect_seq("t1", "HHLHHLHHLDI", 0, -1);
    chk("t1_sent", 32'(sent_count), 32'd3);

    // N=2 H=1 L=1 with counter clear first
    launch(8'd2, 8'd1, 8'd1, 1'b1, 1'b0);
    expect_seq("t2", "CCCCHLHLDI", 0, -1);
    chk("t2_sent", 32'(sent_count), 32'd2);

    // N=0: straight to DONE
    launch(8'd0, 8'd5, 8'd5, 1'b0, 1'b0);
    expect_seq("t3", "DI", 0, -1);
    chk("t3_sent", 32'(sent_count), 32'd0);

    // N=5 H=3 L=3, abort during second HIGH
    launch(8'd5, 8'd3, 8'd3, 1'b0, 1'b0);
    expect_seq("t4", "HHHLLLHHXI", 0, 7);
    chk("t4_sent", 32'(sent_count), 32'd2);

    // start repeated while busy with different length: ignored
    launch(8'd2, 8'd1, 8'd1, 1'b0, 1'b0);
    burst_len = 8'd7;
    expect_seq("t5", "HLHLDII", 4, -1);
    chk("t5_sent", 32'(sent_count), 32'd2);

    // start with active low: ignored, sent_count holds
    active = 1'b0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    expect_seq("t5_inactive", "II", 0, -1);
    active = 1'b1;
    chk("t5_hold_sent", 32'(sent_count), 32'd2);

    // abort in IDLE: no effect
    abort = 1'b1;
    step();
    abort = 1'b0;
    expect_seq("idle_abort", "I", 0, -1);

    // abort together with start: start wins
    launch(8'd1, 8'd1, 8'd1, 1'b0, 1'b1);
    expect_seq("start_abort", "HLDI", 0, -1);
    chk("start_abort_sent", 32'(sent_count), 32'd1);

    // active dropped during LOW ends the burst as aborted
    launch(8'd3, 8'd2, 8'd2, 1'b0, 1'b0);
    expect_seq("t7", "HHL", 0, -1);
    active = 1'b0;
    step();
    expect_seq("t7b", "XI", 0, -1);
    active = 1'b1;
    chk("t7_sent", 32'(sent_count), 32'd1);

    // H=0 L=0 treated as 1: toggling every cycle
    launch(8'd4, 8'd0, 8'd0, 1'b0, 1'b0);
    expect_seq("t6", "HLHLHLHLDI", 0, -1);
    chk("t6_sent", 32'(sent_count), 32'd4);

    // async reset mid-burst
    launch(8'd4, 8'd0, 8'd0, 1'b0, 1'b0);
    expect_seq("t6r", "HLH", 0, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", 32'(obs_vec()), 32'd0);
    chk("midreset_sent", 32'(sent_count), 32'd0);
    chk("midreset_state", 32'(dbg_state), 32'd0);
    step();
    rst_n = 1'b1;
    expect_seq("t6r_after", "III", 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
